// File: rtl/addsub_pkg.sv
// Shared constants, state encoding and sizing helper for the serial add/subtract accumulator.
package addsub_pkg;

    localparam int OP_SUB = 0;
    localparam int OP_ACC = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for STEPS states; never narrower than one bit so STEPS=1 still has a counter.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/serial_addsub_acc_digit_adder.sv
// DIGIT-wide combinational adder slice; the serial engine feeds it one digit per clock.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_addsub_acc.sv
// Digit-serial add/subtract engine with valid/ready handshakes and a chaining accumulator.
module serial_addsub_acc
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW = clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             msb_a;
    logic             msb_b;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] first_op;
    logic [WIDTH-1:0] second_op;

    // A same-cycle accumulator clear must also zero an ACC-sourced operand.
    assign first_op  = op[OP_ACC] ? (acc_clr ? '0 : acc) : a_in;
    assign second_op = b_in ^ {WIDTH{op[OP_SUB]}};
    assign in_ready  = (state == IDLE);

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a   (op_a[DIGIT-1:0]),
        .b   (op_b[DIGIT-1:0]),
        .cin (carry),
        .sum (dig_sum),
        .cout(dig_cout)
    );

    // sum_full is what the result would be if this RUN cycle were the last one:
    // the new digit on top of the digits already collected.
    if (DIGIT < WIDTH) begin : g_shift
        logic [WIDTH-DIGIT-1:0] sum_sh;

        assign sum_full = {dig_sum, sum_sh};

        always_ff @(posedge clk) begin
            if (reset) begin
                sum_sh <= '0;
            end else if (state == RUN) begin
                sum_sh <= sum_full[WIDTH-1:DIGIT];
            end
        end
    end else begin : g_single
        assign sum_full = dig_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            msb_a     <= 1'b0;
            msb_b     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= first_op;
                        op_b  <= second_op;
                        carry <= op[OP_SUB];
                        msb_a <= first_op[WIDTH-1];
                        msb_b <= second_op[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= dig_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= sum_full;
                        cout      <= dig_cout;
                        ovf       <= (msb_a == msb_b) && (sum_full[WIDTH-1] != msb_a);
                        zero      <= (sum_full == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase

            // Clear has priority over loading a freshly accepted result.
            if (acc_clr) begin
                acc <= '0;
            end else if (state == DONE && out_ready) begin
                acc <= result;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_acc.sv
// Directed, table-driven bench for serial_addsub_acc at DIGIT=1, plus latency checks at DIGIT=4 and DIGIT=8.
module tb_serial_addsub_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       in_valid, in_ready, acc_clr, out_valid, out_ready, cout, ovf, zero;
    logic [1:0] op;
    logic [7:0] a_in, b_in, result, acc;

    logic       d4_in_valid, d4_in_ready, d4_acc_clr, d4_out_valid, d4_out_ready, d4_cout, d4_ovf, d4_zero;
    logic [1:0] d4_op;
    logic [7:0] d4_a_in, d4_b_in, d4_result, d4_acc;

    logic       d8_in_valid, d8_in_ready, d8_acc_clr, d8_out_valid, d8_out_ready, d8_cout, d8_ovf, d8_zero;
    logic [1:0] d8_op;
    logic [7:0] d8_a_in, d8_b_in, d8_result, d8_acc;

    serial_addsub_acc #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_in(a_in), .b_in(b_in), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero), .acc(acc)
    );

    serial_addsub_acc #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready), .op(d4_op),
        .a_in(d4_a_in), .b_in(d4_b_in), .acc_clr(d4_acc_clr), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .result(d4_result), .cout(d4_cout), .ovf(d4_ovf), .zero(d4_zero), .acc(d4_acc)
    );

    serial_addsub_acc #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(d8_in_valid), .in_ready(d8_in_ready), .op(d8_op),
        .a_in(d8_a_in), .b_in(d8_b_in), .acc_clr(d8_acc_clr), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .result(d8_result), .cout(d8_cout), .ovf(d8_ovf), .zero(d8_zero), .acc(d8_acc)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic clr);
        op       = o;
        a_in     = a;
        b_in     = b;
        acc_clr  = clr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{2'b00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{2'b01, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0};

        in_valid = 0; acc_clr = 0; out_ready = 0; op = 0; a_in = 0; b_in = 0;
        d4_in_valid = 0; d4_acc_clr = 0; d4_out_ready = 0; d4_op = 0; d4_a_in = 0; d4_b_in = 0;
        d8_in_valid = 0; d8_acc_clr = 0; d8_out_ready = 0; d8_op = 0; d8_a_in = 0; d8_b_in = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {cout, ovf, zero}, 0);
        checkOutput("reset_acc", acc, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            checkOutput($sformatf("vec%0d_in_ready_busy", i), in_ready, 0);
            waitDone(cyc);
            checkOutput($sformatf("vec%0d_latency", i), cyc, 8);
            checkOutput($sformatf("vec%0d_result", i), result, vecs[i].res);
            checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].c);
            checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].v);
            checkOutput($sformatf("vec%0d_zero", i), zero, vecs[i].z);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checkOutput($sformatf("vec%0d_acc", i), acc, vecs[i].res);
            checkOutput($sformatf("vec%0d_idle", i), {in_ready, out_valid}, 2'b10);
        end

        // Chained accumulator adds with the consumer always ready.
        out_ready = 1'b1;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checkOutput("chain_clr_acc", acc, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(2'b10, 8'hAA, 8'h10, 1'b0);
            waitDone(cyc);
            checkOutput($sformatf("chain%0d_result", k), result, k * 16);
            tick();
            checkOutput($sformatf("chain%0d_acc", k), acc, k * 16);
        end
        applyStimulus(2'b10, 8'hAA, 8'h10, 1'b0);
        waitDone(cyc);
        checkOutput("chain4_result", result, 8'h40);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checkOutput("clr_wins_acc", acc, 0);
        checkOutput("clr_wins_out_valid", out_valid, 0);

        // Clear coinciding with an ACC-sourced accept forces the first operand to zero.
        applyStimulus(2'b10, 8'h00, 8'h25, 1'b0);
        waitDone(cyc);
        tick();
        checkOutput("preload_acc", acc, 8'h25);
        applyStimulus(2'b10, 8'hAA, 8'h07, 1'b1);
        waitDone(cyc);
        checkOutput("clr_accept_result", result, 8'h07);
        tick();
        checkOutput("clr_accept_acc", acc, 8'h07);
        out_ready = 1'b0;

        // Backpressure: results hold and new operands are refused while DONE.
        applyStimulus(2'b00, 8'h12, 8'h34, 1'b0);
        waitDone(cyc);
        for (int j = 0; j < 5; j++) begin
            op = 2'b01; a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
            tick();
            checkOutput($sformatf("bp%0d_result", j), result, 8'h46);
            checkOutput($sformatf("bp%0d_flags", j), {cout, ovf, zero}, 3'b000);
            checkOutput($sformatf("bp%0d_hold", j), {out_valid, in_ready}, 2'b10);
            checkOutput($sformatf("bp%0d_acc", j), acc, 8'h07);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release_state", {out_valid, in_ready}, 2'b01);
        checkOutput("bp_release_acc", acc, 8'h46);
        tick();
        checkOutput("bp_no_new_op", {out_valid, in_ready}, 2'b01);

        // Reset partway through RUN drops the operation.
        applyStimulus(2'b00, 8'h11, 8'h22, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrun_reset_state", {out_valid, in_ready}, 2'b01);
        checkOutput("midrun_reset_acc", acc, 0);
        checkOutput("midrun_reset_result", result, 0);
        repeat (10) tick();
        checkOutput("midrun_reset_no_result", out_valid, 0);

        // Wider digits: same answers, shorter latency.
        for (int i = 0; i < 3; i += 2) begin
            d4_op = vecs[i].op; d4_a_in = vecs[i].a; d4_b_in = vecs[i].b; d4_in_valid = 1'b1;
            tick();
            d4_in_valid = 1'b0;
            cyc = 0;
            while (!d4_out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            checkOutput($sformatf("d4_vec%0d_latency", i), cyc, 2);
            checkOutput($sformatf("d4_vec%0d_result", i), d4_result, vecs[i].res);
            checkOutput($sformatf("d4_vec%0d_flags", i), {d4_cout, d4_ovf, d4_zero}, {vecs[i].c, vecs[i].v, vecs[i].z});
            d4_out_ready = 1'b1;
            tick();
            d4_out_ready = 1'b0;
            checkOutput($sformatf("d4_vec%0d_acc", i), d4_acc, vecs[i].res);

            d8_op = vecs[i].op; d8_a_in = vecs[i].a; d8_b_in = vecs[i].b; d8_in_valid = 1'b1;
            tick();
            d8_in_valid = 1'b0;
            cyc = 0;
            while (!d8_out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            checkOutput($sformatf("d8_vec%0d_latency", i), cyc, 1);
            checkOutput($sformatf("d8_vec%0d_result", i), d8_result, vecs[i].res);
            checkOutput($sformatf("d8_vec%0d_flags", i), {d8_cout, d8_ovf, d8_zero}, {vecs[i].c, vecs[i].v, vecs[i].z});
            d8_out_ready = 1'b1;
            tick();
            d8_out_ready = 1'b0;
            checkOutput($sformatf("d8_vec%0d_acc", i), d8_acc, vecs[i].res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
